// File: rtl/hog_stream_arbiter_if.sv
// rtl/hog_stream_arbiter_if.sv - stream-side and bus-side handshake bundle for hog_stream_arbiter
//
// Signals:
//   s_data   NUM_STREAMS*BUS_WIDTH  packed serializer beats, stream i at [i*BUS_WIDTH +: BUS_WIDTH]
//   s_valid  NUM_STREAMS            per-stream beat valid
//   s_ready  NUM_STREAMS            per-stream beat accept (driven by the arbiter)
//   m_data   BUS_WIDTH              forwarded beat
//   m_valid  1                      forwarded beat valid
//   m_ready  1                      bus-master accept
//   m_src    SRC_WIDTH              level index of the forwarded beat
//   m_first  1                      first beat of a window
//   m_last   1                      last beat of a window
//
// Modports:
//   master  the arbiter's view: owns s_ready and the whole m_* side except m_ready
//   slave   the surrounding logic's view: serializers and bus master
interface hog_stream_arbiter_if #(
    parameter int NUM_STREAMS = 15,
    parameter int BUS_WIDTH   = 128,
    parameter int SRC_WIDTH   = 4
) ();

    logic [NUM_STREAMS*BUS_WIDTH-1:0] s_data;
    logic [NUM_STREAMS-1:0]           s_valid;
    logic [NUM_STREAMS-1:0]           s_ready;
    logic [BUS_WIDTH-1:0]             m_data;
    logic                             m_valid;
    logic                             m_ready;
    logic [SRC_WIDTH-1:0]             m_src;
    logic                             m_first;
    logic                             m_last;

    modport master (
        input  s_data,
        input  s_valid,
        output s_ready,
        output m_data,
        output m_valid,
        input  m_ready,
        output m_src,
        output m_first,
        output m_last
    );

    modport slave (
        output s_data,
        output s_valid,
        input  s_ready,
        input  m_data,
        input  m_valid,
        output m_ready,
        input  m_src,
        input  m_first,
        input  m_last
    );

endinterface

// File: rtl/hog_stream_arbiter.sv
// rtl/hog_stream_arbiter.sv - round-robin window arbiter sharing one bus-master port among HOG level streams
//
// Grants one pyramid-level stream at a time, holds the grant for a full window of
// BEATS_PER_WINDOW beats and forwards each beat through a single registered output
// stage tagged with the source level and first/last markers.
//
// Ports:
//   clk            in   stream clock
//   rst_n          in   asynchronous active-low reset
//   stream_enable  in   per-level enable mask, only looked at while arbitrating
//   bus            hog_stream_arbiter_if.master: s_data/s_valid/s_ready per stream,
//                  m_data/m_valid/m_ready/m_src/m_first/m_last toward the bus master
//   busy           out  high while a grant is held
module hog_stream_arbiter #(
    parameter int NUM_STREAMS      = 15,
    parameter int BUS_WIDTH        = 128,
    parameter int BEATS_PER_WINDOW = 10,
    parameter int SRC_WIDTH        = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_STREAMS-1:0] stream_enable,
    hog_stream_arbiter_if.master   bus,
    output logic                   busy
);

    localparam int CNT_W = (BEATS_PER_WINDOW > 1) ? $clog2(BEATS_PER_WINDOW) : 1;
    localparam logic [CNT_W-1:0]     LAST_BEAT = CNT_W'(BEATS_PER_WINDOW - 1);
    localparam logic [SRC_WIDTH-1:0] LAST_SRC  = SRC_WIDTH'(NUM_STREAMS - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_nxt;

    logic [SRC_WIDTH-1:0]   grant;
    logic [SRC_WIDTH-1:0]   last_grant;
    logic [CNT_W-1:0]       beat_cnt;

    logic [NUM_STREAMS-1:0] cand;
    logic [SRC_WIDTH-1:0]   pick_hi;
    logic [SRC_WIDTH-1:0]   pick_lo;
    logic                   found_hi;
    logic                   found_lo;
    logic [SRC_WIDTH-1:0]   pick;
    logic                   pick_found;

    logic [BUS_WIDTH-1:0]   grant_data;
    logic                   grant_valid;
    logic                   load;
    logic                   accept;
    logic                   last_beat;
    logic [NUM_STREAMS-1:0] s_ready_c;

    logic [BUS_WIDTH-1:0]   m_data_q;
    logic                   m_valid_q;
    logic [SRC_WIDTH-1:0]   m_src_q;
    logic                   m_first_q;
    logic                   m_last_q;

    assign cand = bus.s_valid & stream_enable;

    // Round-robin pick. The upper pass finds the first candidate above last_grant;
    // the lower pass finds the lowest candidate overall, which is the wrapped
    // choice when nothing above last_grant is requesting.
    always_comb begin
        pick_hi  = '0;
        pick_lo  = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        for (int j = 0; j < NUM_STREAMS; j++) begin
            if (cand[j] && (SRC_WIDTH'(j) > last_grant) && !found_hi) begin
                found_hi = 1'b1;
                pick_hi  = SRC_WIDTH'(j);
            end
            if (cand[j] && !found_lo) begin
                found_lo = 1'b1;
                pick_lo  = SRC_WIDTH'(j);
            end
        end
        pick       = found_hi ? pick_hi : pick_lo;
        pick_found = found_lo;
    end

    // Beat and valid of the granted stream.
    always_comb begin
        grant_data  = '0;
        grant_valid = 1'b0;
        for (int j = 0; j < NUM_STREAMS; j++) begin
            if (SRC_WIDTH'(j) == grant) begin
                grant_data  = bus.s_data[j*BUS_WIDTH +: BUS_WIDTH];
                grant_valid = bus.s_valid[j];
            end
        end
    end

    assign last_beat = (beat_cnt == LAST_BEAT);

    // Next state and stream-side handshake. load is the output register's
    // ability to take a new beat this cycle; it is only offered to the
    // granted stream, and only while a window is in progress.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        accept    = 1'b0;
        s_ready_c = '0;
        case (state)
            ST_IDLE: begin
                if (pick_found) begin
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                load   = ~m_valid_q | bus.m_ready;
                accept = grant_valid & load;
                for (int j = 0; j < NUM_STREAMS; j++) begin
                    if (SRC_WIDTH'(j) == grant) begin
                        s_ready_c[j] = load;
                    end
                end
                if (accept && last_beat) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant bookkeeping. last_grant only moves at the end of a full window, so a
    // stream that stalls mid-window keeps its place in the rotation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant      <= '0;
            last_grant <= LAST_SRC;
            beat_cnt   <= '0;
        end else begin
            if (state == ST_IDLE && pick_found) begin
                grant    <= pick;
                beat_cnt <= '0;
            end
            if (accept) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
                if (last_beat) begin
                    last_grant <= grant;
                end
            end
        end
    end

    // Output stage. A beat is held until the bus master takes it; in IDLE the
    // stage still drains because accept is never set there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_src_q   <= '0;
            m_first_q <= 1'b0;
            m_last_q  <= 1'b0;
        end else if (accept) begin
            m_data_q  <= grant_data;
            m_valid_q <= 1'b1;
            m_src_q   <= grant;
            m_first_q <= (beat_cnt == '0);
            m_last_q  <= last_beat;
        end else if (~m_valid_q | bus.m_ready) begin
            m_valid_q <= 1'b0;
        end
    end

    assign bus.s_ready = s_ready_c;
    assign bus.m_data  = m_data_q;
    assign bus.m_valid = m_valid_q;
    assign bus.m_src   = m_src_q;
    assign bus.m_first = m_first_q;
    assign bus.m_last  = m_last_q;
    assign busy        = (state == ST_BUSY);

endmodule
